// File: rtl/palette_pkg.sv
// Shared types and constants for the sprite palette controller.
package palette_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int unsigned PAL_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;

  // Entry 0 is transparent black and entry 13 is full white; the rest come from the sprite art.
  localparam rgb12_t DEFAULT_PALETTE [PAL_DEPTH] = '{
    12'h000, 12'h68A, 12'hA52, 12'h3C4, 12'h25B, 12'hFD0, 12'hC3C, 12'h888,
    12'h444, 12'hF80, 12'h0CF, 12'h9F6, 12'h530, 12'hFFF, 12'hE9B, 12'h17D
  };

  typedef enum logic [0:0] {IDLE, COPY} ctrl_state_t;

endpackage

// File: rtl/palette_flash.sv
// Beat-triggered brightness flash with per-frame decay, plus the saturating channel adder.
module palette_flash #(
  parameter int unsigned FLASH_PEAK   = 6,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        beat,
  input  logic        vsync_start,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic [3:0]  flash_level
);

  localparam int unsigned CntW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [CntW-1:0] frame_cnt_q;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_level <= 4'd0;
      frame_cnt_q <= '0;
    end else if (beat) begin
      flash_level <= 4'(FLASH_PEAK);
      frame_cnt_q <= '0;
    end else if (vsync_start && (flash_level != 4'd0)) begin
      if (frame_cnt_q == CntW'(DECAY_FRAMES - 1)) begin
        flash_level <= flash_level - 4'd1;
        frame_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign rgb_out = {sat_add(rgb_in[11:8], flash_level),
                    sat_add(rgb_in[7:4],  flash_level),
                    sat_add(rgb_in[3:0],  flash_level)};

endmodule

// File: rtl/palette_ctrl.sv
// Live/shadow sprite palette with vblank-only commit and a two-stage flashed lookup path.
module palette_ctrl
  import palette_pkg::*;
#(
  parameter int unsigned FLASH_PEAK   = 6,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync_start,
  input  logic        pix_valid,
  input  logic [3:0]  pix_index,
  output logic        pix_out_valid,
  output logic [3:0]  pix_red,
  output logic [3:0]  pix_green,
  output logic [3:0]  pix_blue,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_rgb,
  input  logic        commit,
  output logic        commit_pending,
  input  logic        beat,
  output logic [3:0]  flash_level
);

  ctrl_state_t      state_q;
  logic [IDX_W-1:0] copy_idx_q;
  logic             recommit_q;
  rgb12_t           shadow_q [PAL_DEPTH];
  rgb12_t           live_q   [PAL_DEPTH];
  rgb12_t           raw_q;
  logic             v1_q;
  rgb12_t           flashed;

  assign wr_ready = (state_q == IDLE);

  // A commit seen mid-copy is parked in recommit_q so the copy reruns at the next vblank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      copy_idx_q     <= '0;
      commit_pending <= 1'b0;
      recommit_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (commit) commit_pending <= 1'b1;
          if (vsync_start && (commit_pending || commit)) begin
            state_q    <= COPY;
            copy_idx_q <= '0;
          end
        end
        COPY: begin
          copy_idx_q <= copy_idx_q + 1'b1;
          if (copy_idx_q == IDX_W'(PAL_DEPTH - 1)) begin
            state_q        <= IDLE;
            commit_pending <= recommit_q || commit;
            recommit_q     <= 1'b0;
          end else if (commit) begin
            recommit_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        shadow_q[i] <= DEFAULT_PALETTE[i];
        live_q[i]   <= DEFAULT_PALETTE[i];
      end
    end else begin
      if (wr_valid && wr_ready) shadow_q[wr_addr] <= wr_rgb;
      if (state_q == COPY) live_q[copy_idx_q] <= shadow_q[copy_idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q         <= '0;
      v1_q          <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_red       <= 4'd0;
      pix_green     <= 4'd0;
      pix_blue      <= 4'd0;
    end else begin
      raw_q         <= live_q[pix_index];
      v1_q          <= pix_valid;
      pix_out_valid <= v1_q;
      pix_red       <= v1_q ? flashed[11:8] : 4'd0;
      pix_green     <= v1_q ? flashed[7:4]  : 4'd0;
      pix_blue      <= v1_q ? flashed[3:0]  : 4'd0;
    end
  end

  palette_flash #(
    .FLASH_PEAK  (FLASH_PEAK),
    .DECAY_FRAMES(DECAY_FRAMES)
  ) u_flash (
    .clk        (clk),
    .reset_n    (reset_n),
    .beat       (beat),
    .vsync_start(vsync_start),
    .rgb_in     (raw_q),
    .rgb_out    (flashed),
    .flash_level(flash_level)
  );

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl: lookups, shadow commit, flash decay and reset during copy.
module tb_palette_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync_start;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        pix_out_valid;
  logic [3:0]  pix_red, pix_green, pix_blue;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [11:0] wr_rgb;
  logic        commit;
  logic        commit_pending;
  logic        beat;
  logic [3:0]  flash_level;

  int n_cmp = 0;
  int n_err = 0;

  palette_ctrl #(
    .FLASH_PEAK  (6),
    .DECAY_FRAMES(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vsync_start   (vsync_start),
    .pix_valid     (pix_valid),
    .pix_index     (pix_index),
    .pix_out_valid (pix_out_valid),
    .pix_red       (pix_red),
    .pix_green     (pix_green),
    .pix_blue      (pix_blue),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_rgb        (wr_rgb),
    .commit        (commit),
    .commit_pending(commit_pending),
    .beat          (beat),
    .flash_level   (flash_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel, then compare {valid, r, g, b} two edges later.
  task automatic lookup(input string tag, input logic [3:0] idx, input logic [11:0] exp_rgb);
    pix_valid = 1'b1;
    pix_index = idx;
    tick();
    pix_valid = 1'b0;
    pix_index = 4'd0;
    tick();
    check(tag, {19'd0, pix_out_valid, pix_red, pix_green, pix_blue}, {19'd0, 1'b1, exp_rgb});
  endtask

  task automatic write(input logic [3:0] a, input logic [11:0] v);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_rgb   = v;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    tick();
  endtask

  // Counts cycles with wr_ready low; a stuck FSM returns the bound and fails the length check.
  task automatic copy_len(output int n);
    n = 0;
    while (!wr_ready && n < 40) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    reset_n     = 1'b0;
    vsync_start = 1'b0;
    pix_valid   = 1'b0;
    pix_index   = 4'd0;
    wr_valid    = 1'b0;
    wr_addr     = 4'd0;
    wr_rgb      = 12'd0;
    commit      = 1'b0;
    beat        = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_flash", 32'(flash_level), 32'd0);
    check("rst_pending", 32'(commit_pending), 32'd0);
    check("rst_pix_out", {19'd0, pix_out_valid, pix_red, pix_green, pix_blue}, 32'd0);

    lookup("idx13_white", 4'd13, 12'hFFF);
    lookup("idx0_black", 4'd0, 12'h000);

    // Shadow write without commit must not reach the live bank.
    write(4'd5, 12'h123);
    vsync_pulse();
    check("no_commit_ready", 32'(wr_ready), 32'd1);
    lookup("idx5_uncommitted", 4'd5, 12'hFD0);

    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("pending_set", 32'(commit_pending), 32'd1);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    copy_len(n);
    check("copy_len", 32'(n), 32'd16);
    check("pending_clear", 32'(commit_pending), 32'd0);
    lookup("idx5_committed", 4'd5, 12'h123);

    // Write, commit and vsync all in the same cycle.
    wr_valid    = 1'b1;
    wr_addr     = 4'd15;
    wr_rgb      = 12'hABC;
    commit      = 1'b1;
    vsync_start = 1'b1;
    tick();
    wr_valid    = 1'b0;
    commit      = 1'b0;
    vsync_start = 1'b0;
    check("same_cycle_copy_started", 32'(wr_ready), 32'd0);
    check("same_cycle_pending", 32'(commit_pending), 32'd1);
    copy_len(n);
    check("same_cycle_copy_len", 32'(n), 32'd16);
    lookup("idx15_committed", 4'd15, 12'hABC);

    // Flash.
    beat = 1'b1;
    tick();
    beat = 1'b0;
    check("flash_peak", 32'(flash_level), 32'd6);
    lookup("flash_idx13", 4'd13, 12'hFFF);
    lookup("flash_idx1", 4'd1, 12'hCEF);
    for (int i = 0; i < 3; i++) vsync_pulse();
    check("flash_3vs", 32'(flash_level), 32'd6);
    vsync_pulse();
    check("flash_4vs", 32'(flash_level), 32'd5);
    lookup("flash5_idx0", 4'd0, 12'h555);
    for (int i = 0; i < 20; i++) vsync_pulse();
    check("flash_24vs", 32'(flash_level), 32'd0);
    vsync_pulse();
    check("flash_floor", 32'(flash_level), 32'd0);
    beat        = 1'b1;
    vsync_start = 1'b1;
    tick();
    beat        = 1'b0;
    vsync_start = 1'b0;
    check("beat_wins", 32'(flash_level), 32'd6);
    for (int i = 0; i < 3; i++) vsync_pulse();
    check("beat_cnt_reset", 32'(flash_level), 32'd6);
    vsync_pulse();
    check("beat_cnt_decay", 32'(flash_level), 32'd5);

    // Reset on copy cycle 8.
    write(4'd2, 12'hF00);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("copy_running", 32'(wr_ready), 32'd0);
    reset_n = 1'b0;
    #2;
    check("async_rst_pending", 32'(commit_pending), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    check("post_rst_pending", 32'(commit_pending), 32'd0);
    check("post_rst_flash", 32'(flash_level), 32'd0);
    lookup("post_rst_idx2", 4'd2, 12'hA52);
    lookup("post_rst_idx5", 4'd5, 12'hFD0);
    lookup("post_rst_idx15", 4'd15, 12'h17D);
    lookup("post_rst_idx1", 4'd1, 12'h68A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
